// File: rtl/conv_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Package : conv_pkg                                                       |
// | Shared window geometry, fetch FSM states and element index helper.       |
// | Revision: 1.0                                                            |
// ----------------------------------------------------------------------------
package conv_pkg;

   localparam int K        = 3;
   localparam int WIN_SIZE = K * K;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      SHIFT = 3'd2,
      VALID = 3'd3,
      DONE  = 3'd4
   } state_t;

   function automatic logic [3:0] win_idx(input logic [1:0] r, input logic [1:0] c);
      return ({2'b00, r} * 4'd3) + {2'b00, c};
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv_window_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module  : conv_window_reg                                                |
// | 3x3 pixel window store: single-element load, left column shift.          |
// | Revision: 1.0                                                            |
// ----------------------------------------------------------------------------
module conv_window_reg
   import conv_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_en,
   input  logic [1:0]            load_r,
   input  logic [1:0]            load_c,
   input  logic [N-1:0]          load_data,
   input  logic                  shift_en,
   output logic [WIN_SIZE*N-1:0] win_data
);

   logic [N-1:0] r_win [0:WIN_SIZE-1];

   // Shift has priority; the fetch FSM never requests both in one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < WIN_SIZE; i++) r_win[i] <= '0;
      end else if (shift_en) begin
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K - 1; c++)
               r_win[win_idx(2'(r), 2'(c))] <= r_win[win_idx(2'(r), 2'(c + 1))];
      end else if (load_en) begin
         r_win[win_idx(load_r, load_c)] <= load_data;
      end
   end

   for (genvar i = 0; i < WIN_SIZE; i++) begin : g_pack
      assign win_data[i*N +: N] = r_win[i];
   end

endmodule
`default_nettype wire

// File: rtl/conv_window_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module  : conv_window_fetch                                              |
// | Walks all 3x3 windows of a PxP image in raster order, reusing columns.   |
// | Revision: 1.0                                                            |
// ----------------------------------------------------------------------------
module conv_window_fetch
   import conv_pkg::*;
#(
   parameter int N = 8,
   parameter int M = 10,
   parameter int P = 28
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  ram_rd,
   output logic [M-1:0]          ram_adr,
   input  logic [N-1:0]          ram_dataout,
   output logic                  win_valid,
   input  logic                  win_ready,
   output logic [WIN_SIZE*N-1:0] win_data,
   output logic [M-1:0]          win_row,
   output logic [M-1:0]          win_col,
   output logic                  busy,
   output logic                  done
);

   localparam logic [M-1:0] c_row1 = M'(P);
   localparam logic [M-1:0] c_row2 = M'(2 * P);
   localparam logic [M-1:0] c_last = M'(P - 3);
   localparam logic [M-1:0] c_wrap = M'(K);

   state_t         r_state;
   state_t         w_state_nxt;
   logic [M-1:0]   r_row;
   logic [M-1:0]   r_col;
   logic [M-1:0]   r_base;
   logic [1:0]     r_dr;
   logic [1:0]     r_dc;
   logic [1:0]     w_dc;
   logic [M-1:0]   w_off;
   logic           w_last_rd;
   logic           w_accept;
   logic           w_col_more;
   logic           w_row_more;

   assign w_last_rd  = (r_dr == 2'd2);
   assign w_accept   = (r_state == VALID) && win_ready;
   assign w_col_more = (r_col < c_last);
   assign w_row_more = (r_row < c_last);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      ram_rd      = 1'b0;
      w_dc        = r_dc;
      w_off       = '0;
      ram_adr     = '0;
      case (r_state)
         IDLE:  if (start) w_state_nxt = FILL;
         FILL:  if (w_last_rd && (r_dc == 2'd2)) w_state_nxt = VALID;
         SHIFT: if (w_last_rd) w_state_nxt = VALID;
         VALID: begin
            if (w_accept) begin
               if (w_col_more)      w_state_nxt = SHIFT;
               else if (w_row_more) w_state_nxt = FILL;
               else                 w_state_nxt = DONE;
            end
         end
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase

      if ((r_state == FILL) || (r_state == SHIFT)) begin
         ram_rd = 1'b1;
         // A shift only ever refills the rightmost column.
         if (r_state == SHIFT) w_dc = 2'd2;
         case (r_dr)
            2'd1:    w_off = c_row1;
            2'd2:    w_off = c_row2;
            default: w_off = '0;
         endcase
         ram_adr = r_base + w_off + {{(M-2){1'b0}}, w_dc};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row  <= '0;
         r_col  <= '0;
         r_base <= '0;
         r_dr   <= '0;
         r_dc   <= '0;
      end else begin
         case (r_state)
            FILL: begin
               if (w_last_rd) begin
                  r_dr <= '0;
                  r_dc <= (r_dc == 2'd2) ? 2'd0 : r_dc + 2'd1;
               end else begin
                  r_dr <= r_dr + 2'd1;
               end
            end
            SHIFT: r_dr <= w_last_rd ? 2'd0 : r_dr + 2'd1;
            VALID: begin
               if (w_accept) begin
                  if (w_col_more) begin
                     r_col  <= r_col + 1'b1;
                     r_base <= r_base + 1'b1;
                  end else if (w_row_more) begin
                     // base sits at row*P + P-3, so +3 lands on (row+1)*P.
                     r_col  <= '0;
                     r_row  <= r_row + 1'b1;
                     r_base <= r_base + c_wrap;
                  end
               end
            end
            DONE: begin
               r_row  <= '0;
               r_col  <= '0;
               r_base <= '0;
            end
            default: ;
         endcase
      end
   end

   conv_window_reg #(.N(N)) u_win (
      .clk       (clk),
      .rst       (rst),
      .load_en   (ram_rd),
      .load_r    (r_dr),
      .load_c    (w_dc),
      .load_data (ram_dataout),
      .shift_en  (w_accept && w_col_more),
      .win_data  (win_data)
   );

   assign win_valid = (r_state == VALID);
   assign busy      = (r_state != IDLE);
   assign done      = (r_state == DONE);
   assign win_row   = r_row;
   assign win_col   = r_col;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module  : tb_conv_window_fetch                                           |
// | Self-checking bench for conv_window_fetch at P = 28.                     |
// | Revision: 1.0                                                            |
// ----------------------------------------------------------------------------
module tb_conv_window_fetch;

   localparam int N = 8;
   localparam int M = 10;
   localparam int P = 28;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          ram_rd;
   logic [M-1:0]  ram_adr;
   logic [N-1:0]  ram_dataout;
   logic          win_valid;
   logic          win_ready = 1'b0;
   logic [71:0]   win_data;
   logic [M-1:0]  win_row;
   logic [M-1:0]  win_col;
   logic          busy;
   logic          done;

   logic [N-1:0]  mem [0:(1<<M)-1];

   typedef struct {
      int          row;
      int          col;
      logic [71:0] data;
   } vec_t;

   typedef struct {
      int          row;
      int          col;
      logic [71:0] data;
   } sb_t;

   vec_t vec [4];
   sb_t  sb  [$];
   int   adr_fill [9] = '{0, 28, 56, 1, 29, 57, 2, 30, 58};
   int   adr_shift[3] = '{3, 31, 59};
   int   checks = 0;
   int   passed = 0;

   conv_window_fetch #(.N(N), .M(M), .P(P)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .ram_rd      (ram_rd),
      .ram_adr     (ram_adr),
      .ram_dataout (ram_dataout),
      .win_valid   (win_valid),
      .win_ready   (win_ready),
      .win_data    (win_data),
      .win_row     (win_row),
      .win_col     (win_col),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;
   assign ram_dataout = mem[ram_adr];

   function automatic vec_t mk(input int r, input int c, input int a0, input int a1,
                               input int a2, input int a3, input int a4, input int a5,
                               input int a6, input int a7, input int a8);
      vec_t v;
      int   a [9];
      a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
      v.row = r;
      v.col = c;
      v.data = '0;
      for (int i = 0; i < 9; i++) v.data[i*8 +: 8] = 8'(a[i]);
      return v;
   endfunction

   function automatic logic [71:0] exp_win(input int r, input int c);
      logic [71:0] v;
      v = '0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            v[(dr*3+dc)*8 +: 8] = 8'(((r + dr) * P + c + dc) % 256);
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, required %0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_valid"}, win_valid, 0);
      chk({tag, "_done"},  done, 0);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_rd"},    ram_rd, 0);
      chk({tag, "_adr"},   ram_adr, 0);
      chk({tag, "_data"},  win_data, 0);
      chk({tag, "_row"},   win_row, 0);
      chk({tag, "_col"},   win_col, 0);
   endtask

   task automatic wait_valid(input int limit, output int n);
      n = 0;
      while (!win_valid && n < limit) begin
         step();
         n++;
      end
      if (!win_valid) chk("valid_timeout", win_valid, 1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic load_pass();
      sb.delete();
      for (int r = 0; r < P - 2; r++)
         for (int c = 0; c < P - 2; c++)
            sb.push_back('{r, c, exp_win(r, c)});
   endtask

   task automatic pop_compare();
      sb_t e;
      if (sb.size() == 0) begin
         checks++;
         $display("FAIL sb_empty: got window (%0d,%0d), required none", win_row, win_col);
      end else begin
         e = sb.pop_front();
         chk("sb_data", win_data, e.data);
         chk("sb_pos", {win_row, win_col}, {M'(e.row), M'(e.col)});
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      int acc;
      int last_acc;
      int done_n;
      int done_cnt;
      int busy_fall;
      bit stopped;

      for (int i = 0; i < (1 << M); i++) mem[i] = 8'(i % 256);
      vec[0] = mk(0, 0, 0, 1, 2, 28, 29, 30, 56, 57, 58);
      vec[1] = mk(0, 1, 1, 2, 3, 29, 30, 31, 57, 58, 59);
      vec[2] = mk(1, 0, 28, 29, 30, 56, 57, 58, 84, 85, 86);
      vec[3] = mk(25, 25, 213, 214, 215, 241, 242, 243, 13, 14, 15);

      // Reset, then first FILL address sequence and window (0,0)
      @(negedge clk);
      do_reset();
      check_idle("reset");
      pulse_start();
      for (int i = 0; i < 9; i++) begin
         chk("fill_rd", ram_rd, 1);
         chk("fill_adr", ram_adr, M'(adr_fill[i]));
         chk("fill_valid_low", win_valid, 0);
         step();
      end
      chk("win00_valid", win_valid, 1);
      chk("win00_data", win_data, vec[0].data);
      chk("win00_pos", {win_row, win_col}, {M'(vec[0].row), M'(vec[0].col)});

      // Accept (0,0): SHIFT reads column 3
      win_ready = 1'b1;
      step();
      win_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("shift_rd", ram_rd, 1);
         chk("shift_adr", ram_adr, M'(adr_shift[i]));
         step();
      end
      chk("win01_valid", win_valid, 1);
      chk("win01_data", win_data, vec[1].data);
      chk("win01_pos", {win_row, win_col}, {M'(vec[1].row), M'(vec[1].col)});

      // Back-pressure: window must hold still
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_valid", win_valid, 1);
         chk("hold_data", win_data, vec[1].data);
         chk("hold_pos", {win_row, win_col}, {M'(0), M'(1)});
         chk("hold_rd", ram_rd, 0);
         chk("hold_adr", ram_adr, 0);
      end

      // Walk to (0,25), then row change into (1,0)
      for (int i = 0; i < 24; i++) begin
         win_ready = 1'b1;
         step();
         win_ready = 1'b0;
         wait_valid(10, n);
      end
      chk("shift_latency", n, 3);
      chk("win025_pos", {win_row, win_col}, {M'(0), M'(25)});
      chk("win025_data", win_data, exp_win(0, 25));
      win_ready = 1'b1;
      step();
      win_ready = 1'b0;
      chk("rowchg_adr0", ram_adr, M'(28));
      wait_valid(20, n);
      chk("rowchg_latency", n, 9);
      chk("win10_data", win_data, vec[2].data);
      chk("win10_pos", {win_row, win_col}, {M'(vec[2].row), M'(vec[2].col)});

      // Full pass with win_ready held high, scoreboard-checked
      do_reset();
      load_pass();
      win_ready = 1'b1;
      pulse_start();
      acc = 0; last_acc = -1; done_n = -1; done_cnt = 0; busy_fall = -1;
      for (int k = 0; k < 3000; k++) begin
         if (win_valid && win_ready) begin
            acc++;
            last_acc = k + 1;
            for (int v = 0; v < 4; v++)
               if (M'(vec[v].row) == win_row && M'(vec[v].col) == win_col)
                  chk("vec_win", win_data, vec[v].data);
            pop_compare();
         end
         if (done) begin
            done_cnt++;
            if (done_n < 0) done_n = k;
         end
         if (!busy) begin
            busy_fall = k;
            break;
         end
         step();
      end
      chk("pass_windows", acc, 676);
      chk("pass_last_accept", last_acc, 2860);
      chk("pass_done_edge", done_n, 2860);
      chk("pass_done_width", done_cnt, 1);
      chk("pass_busy_fall", busy_fall, 2861);
      chk("pass_sb_empty", sb.size(), 0);

      // Mid-pass start is ignored; reset at (3,7) aborts
      load_pass();
      pulse_start();
      stopped = 1'b0;
      for (int k = 0; k < 2000; k++) begin
         start = (k == 40 || k == 41) ? 1'b1 : 1'b0;
         if (win_valid) begin
            if (win_row == M'(3) && win_col == M'(7)) begin
               win_ready = 1'b0;
               stopped = 1'b1;
               break;
            end
            pop_compare();
         end
         step();
      end
      start = 1'b0;
      chk("abort_reached", stopped, 1);
      chk("abort_win_data", win_data, exp_win(3, 7));
      #2 rst = 1'b1;
      #1 check_idle("abort");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      step();
      chk("abort_idle_busy", busy, 0);
      pulse_start();
      wait_valid(20, n);
      chk("restart_latency", n, 9);
      chk("restart_data", win_data, vec[0].data);
      chk("restart_pos", {win_row, win_col}, {M'(0), M'(0)});

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
